// File: rtl/haar_cascade_evaluator.sv
// haar_cascade_evaluator
// Evaluates a multi-stage Haar cascade on one detection window. It walks a classifier
// database of stage headers {N, stage_threshold} and 11-word two-rectangle records,
// fetches eight integral-image corners per record, and accumulates leaf values into a
// saturating per-stage sum. The first rejecting stage ends the window early.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   start, win_base   start one window (accepted in idle only), window base address
//   busy, done        busy from accepted start through the done cycle, one-cycle done
//   face              1 when every stage passed; held until the next accepted start
//   reject_stage      failing stage index, or NUM_STAGES on pass; held
//   cfg_err           a stage header asked for more than MAX_CLASSIFIERS records
//   db_rd/db_addr     database read request, data returns on db_data one cycle later
//   ii_rd/ii_addr     integral-image read request, data returns on ii_data one cycle later
module haar_cascade_evaluator #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned ACC_WIDTH       = 24,
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned MAX_CLASSIFIERS = 32,
    parameter int unsigned DB_ADDR_WIDTH   = 12,
    parameter int unsigned II_ADDR_WIDTH   = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [II_ADDR_WIDTH-1:0]        win_base,
    output logic                            busy,
    output logic                            done,
    output logic                            face,
    output logic [$clog2(NUM_STAGES+1)-1:0] reject_stage,
    output logic                            cfg_err,
    output logic                            db_rd,
    output logic [DB_ADDR_WIDTH-1:0]        db_addr,
    input  logic [DATA_WIDTH-1:0]           db_data,
    output logic                            ii_rd,
    output logic [II_ADDR_WIDTH-1:0]        ii_addr,
    input  logic [DATA_WIDTH-1:0]           ii_data
);
    localparam int unsigned STAGE_W = $clog2(NUM_STAGES + 1);
    localparam int unsigned CNT_W   = $clog2(MAX_CLASSIFIERS + 1);

    localparam logic [DATA_WIDTH-1:0] MAX_N      = DATA_WIDTH'(MAX_CLASSIFIERS);
    localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0]    ALL_PASS   = STAGE_W'(NUM_STAGES);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Record word positions: 0..3 rect1 corners, 4..7 rect2 corners, then these.
    localparam logic [3:0] W_THR   = 4'd8;
    localparam logic [3:0] W_LEFT  = 4'd9;
    localparam logic [3:0] W_RIGHT = 4'd10;

    typedef enum logic [2:0] {StIdle, StHdr, StRec, StCorn, StEval, StSchk, StDone} state_e;

    state_e                       state_q, state_d;
    logic                         phase_q, phase_d;   // 0 = issue read, 1 = capture data
    logic [3:0]                   idx_q, idx_d;
    logic [DB_ADDR_WIDTH-1:0]     db_addr_q, db_addr_d;
    logic [II_ADDR_WIDTH-1:0]     win_base_q, win_base_d;
    logic [STAGE_W-1:0]           stage_q, stage_d;
    logic [CNT_W-1:0]             n_q, n_d;
    logic [CNT_W-1:0]             cls_q, cls_d;
    logic [DATA_WIDTH-1:0]        sthr_q, sthr_d;
    logic [DATA_WIDTH-1:0]        rec_q [11];
    logic [DATA_WIDTH-1:0]        rec_d [11];
    logic signed [ACC_WIDTH-1:0]  feat_q, feat_d;
    logic signed [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic                         face_q, face_d;
    logic [STAGE_W-1:0]           reject_q, reject_d;
    logic                         cfg_err_q, cfg_err_d;

    logic signed [ACC_WIDTH-1:0]  ii_ext, thr_ext, sthr_ext, leaf_ext, sum_sat;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic                         corner_pos;

    assign ii_ext   = ACC_WIDTH'(ii_data);
    assign thr_ext  = ACC_WIDTH'($signed(rec_q[W_THR]));
    assign sthr_ext = ACC_WIDTH'($signed(sthr_q));
    assign leaf_ext = (feat_q < thr_ext) ? ACC_WIDTH'($signed(rec_q[W_LEFT]))
                                         : ACC_WIDTH'($signed(rec_q[W_RIGHT]));
    // One guard bit detects overflow; clamp instead of wrapping.
    assign sum_wide = {sum_q[ACC_WIDTH-1], sum_q} + {leaf_ext[ACC_WIDTH-1], leaf_ext};
    assign sum_sat  = (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
                    ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                    : sum_wide[ACC_WIDTH-1:0];
    // feature = (A - B - C + D)rect1 - (A - B - C + D)rect2, folded into per-corner signs.
    assign corner_pos = idx_q[2:0] inside {3'd0, 3'd3, 3'd5, 3'd6};

    assign ii_addr      = win_base_q + rec_q[idx_q][II_ADDR_WIDTH-1:0];
    assign db_addr      = db_addr_q;
    assign face         = face_q;
    assign reject_stage = reject_q;
    assign cfg_err      = cfg_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            idx_q      <= '0;
            db_addr_q  <= '0;
            win_base_q <= '0;
            stage_q    <= '0;
            n_q        <= '0;
            cls_q      <= '0;
            sthr_q     <= '0;
            rec_q      <= '{default: '0};
            feat_q     <= '0;
            sum_q      <= '0;
            face_q     <= 1'b0;
            reject_q   <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            db_addr_q  <= db_addr_d;
            win_base_q <= win_base_d;
            stage_q    <= stage_d;
            n_q        <= n_d;
            cls_q      <= cls_d;
            sthr_q     <= sthr_d;
            rec_q      <= rec_d;
            feat_q     <= feat_d;
            sum_q      <= sum_d;
            face_q     <= face_d;
            reject_q   <= reject_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        db_addr_d  = db_addr_q;
        win_base_d = win_base_q;
        stage_d    = stage_q;
        n_d        = n_q;
        cls_d      = cls_q;
        sthr_d     = sthr_q;
        rec_d      = rec_q;
        feat_d     = feat_q;
        sum_d      = sum_q;
        face_d     = face_q;
        reject_d   = reject_q;
        cfg_err_d  = cfg_err_q;
        busy       = (state_q != StIdle);
        done       = 1'b0;
        db_rd      = 1'b0;
        ii_rd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StHdr;
                    phase_d    = 1'b0;
                    idx_d      = '0;
                    db_addr_d  = '0;
                    win_base_d = win_base;
                    stage_d    = '0;
                    face_d     = 1'b0;
                    reject_d   = '0;
                    cfg_err_d  = 1'b0;
                end
            end
            StHdr: begin
                if (!phase_q) begin
                    db_rd     = 1'b1;
                    phase_d   = 1'b1;
                    db_addr_d = db_addr_q + DB_ADDR_WIDTH'(1);
                end else begin
                    phase_d = 1'b0;
                    if (idx_q == 4'd0) begin
                        if (db_data > MAX_N) begin
                            n_d       = CNT_W'(MAX_CLASSIFIERS);
                            cfg_err_d = 1'b1;
                        end else begin
                            n_d = CNT_W'(db_data);
                        end
                        idx_d = 4'd1;
                    end else begin
                        sthr_d  = db_data;
                        sum_d   = '0;
                        cls_d   = '0;
                        idx_d   = '0;
                        state_d = (n_q == '0) ? StSchk : StRec;
                    end
                end
            end
            StRec: begin
                if (!phase_q) begin
                    db_rd     = 1'b1;
                    phase_d   = 1'b1;
                    db_addr_d = db_addr_q + DB_ADDR_WIDTH'(1);
                end else begin
                    phase_d      = 1'b0;
                    rec_d[idx_q] = db_data;
                    if (idx_q == W_RIGHT) begin
                        idx_d   = '0;
                        feat_d  = '0;
                        state_d = StCorn;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StCorn: begin
                if (!phase_q) begin
                    ii_rd   = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    feat_d  = corner_pos ? feat_q + ii_ext : feat_q - ii_ext;
                    if (idx_q == 4'd7) begin
                        idx_d   = '0;
                        state_d = StEval;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StEval: begin
                sum_d   = sum_sat;
                cls_d   = cls_q + CNT_W'(1);
                state_d = (cls_q + CNT_W'(1) < n_q) ? StRec : StSchk;
            end
            StSchk: begin
                if (sum_q < sthr_ext) begin
                    face_d   = 1'b0;
                    reject_d = stage_q;
                    state_d  = StDone;
                end else if (stage_q == LAST_STAGE) begin
                    face_d   = 1'b1;
                    reject_d = ALL_PASS;
                    state_d  = StDone;
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                    idx_d   = '0;
                    phase_d = 1'b0;
                    state_d = StHdr;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/haar_cascade_evaluator.md
# haar_cascade_evaluator

Parametrised multi-stage Haar cascade evaluator for one detection window. It walks a classifier database of stage headers and two-rectangle weak-classifier records, fetches integral-image corners, and accumulates leaf values per stage. It early-exits on the first rejecting stage and reports face/no-face with the reject stage index. It sits between the integral-image buffer and the detection-result collector in the face detection system.

## Interface
- DATA_WIDTH, 16, database and integral-image word width
- ACC_WIDTH, 24, signed rectangle/feature/stage-sum width
- NUM_STAGES, 3, stages evaluated per window
- MAX_CLASSIFIERS, 32, upper bound on classifiers per stage
- DB_ADDR_WIDTH, 12, database address width
- II_ADDR_WIDTH, 7, integral-image address width (10x10 window fits)

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin evaluating one window; sampled in IDLE only
- win_base  input  II_ADDR_WIDTH  window base address; latched on accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the result is valid
- face  output  1  1 = all stages passed; held until next accepted start
- reject_stage  output  $clog2(NUM_STAGES+1)  failing stage index, or NUM_STAGES on pass; held
- cfg_err  output  1  sticky per window: some stage count exceeded MAX_CLASSIFIERS
- db_rd, db_addr  output  1, DB_ADDR_WIDTH  database read request/address
- db_data  input  DATA_WIDTH  database data, valid the cycle after db_rd
- ii_rd, ii_addr  output  1, II_ADDR_WIDTH  integral-image read request/address
- ii_data  input  DATA_WIDTH  unsigned integral value, valid the cycle after ii_rd

## Operation
- Database layout: each stage starts with a header {N, stage_threshold}, followed by N records of 11 words each: r1 offsets A,B,C,D; r2 offsets A,B,C,D; threshold; left; right. Stages are contiguous and start at address 0 for every window.
- FSM states: IDLE -> HDR (2 reads) -> REC (11 db reads) -> CORN (8 ii reads) -> EVAL -> back to REC while classifiers remain, else SCHK. SCHK goes to HDR of the next stage, or to DONE on reject or after the last stage. DONE -> IDLE.
- Reads are non-pipelined: each read issues in one cycle (rd=1) and captures in the next (rd=0). At most one request is outstanding.
- ii_addr = win_base + offset, modulo 2^II_ADDR_WIDTH. db_addr increments by one per read and wraps modulo 2^DB_ADDR_WIDTH.
- rect = A - B - C + D, computed in ACC_WIDTH signed arithmetic. feature = rect1 - rect2.
- EVAL: if feature < sign-extended threshold, add signed left to stage_sum; otherwise add signed right. stage_sum is cleared at each HDR.
- stage_sum saturates at the ACC_WIDTH signed min/max, and never wraps.
- SCHK: the stage passes if stage_sum >= sign-extended stage_threshold.
- On fail: face=0, reject_stage = current stage index. On passing the final stage: face=1, reject_stage = NUM_STAGES.
- N = 0: the stage is evaluated with stage_sum = 0.
- N > MAX_CLASSIFIERS: evaluate only MAX_CLASSIFIERS records, set cfg_err, and continue from the next sequential address.

## Timing
- Reset values: busy, done, face, cfg_err, db_rd and ii_rd are all 0. reject_stage = 0, addresses = 0, FSM in IDLE.
- Accepted start at edge t: busy=1 from t, first db_rd in cycle t+1.
- Cycles per stage: 4 (header) + 39*N' + 1 (SCHK), where N' is the clamped count. DONE occupies 1 cycle, with done=1 and busy falling at its end.
- start while busy is ignored.
- Outputs are valid in the done cycle and held through IDLE.
- cfg_err, face and reject_stage clear on the next accepted start.
- Reset mid-window returns the FSM to IDLE immediately, with outputs at their reset values and no done pulse.

## Test plan
- Single stage passes: N=1, left=5, right=-3, threshold=0, stage_threshold=4, rect1=10, rect2=20 (feature=-10 < 0) -> done 5+39+1 cycles after start, face=0 only if NUM_STAGES>1 fails later; with all three stages identical -> face=1, reject_stage=3, latency 3*44+1.
- Reject at stage 1: stage 0 as above, stage 1 stage_threshold=100 -> face=0, reject_stage=1, no db reads beyond the stage-1 records.
- Right branch and tie: feature equals threshold -> right is added. stage_sum equals stage_threshold -> pass.
- Saturation: left=0x7FFF repeated 32 times with ACC_WIDTH=16 -> stage_sum holds at 32767 and does not wrap negative.
- Overflow count: N=40, MAX_CLASSIFIERS=32 -> cfg_err=1, exactly 32 records read, next header read at address 2+32*11.
- Async reset asserted during CORN, and start while busy -> outputs zero, no done pulse; a fresh start then gives the same result as a clean run. start pulsed mid-window -> no effect.
